// File: rtl/dlf_ctrl_pkg.sv
// dlf_ctrl_pkg: state/gear encodings and default tuning constants for the DLF lock controller
package dlf_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_ACQ_FAST,
    ST_ACQ_MED,
    ST_TRACK,
    ST_LOCKED
  } state_t;
  localparam logic [1:0] GEAR_FAST   = 2'd2;
  localparam logic [1:0] GEAR_MED    = 2'd1;
  localparam logic [1:0] GEAR_NARROW = 2'd0;
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_ACQ_TOL    = 12;
  localparam int DEF_LOCK_TOL   = 4;
  localparam int DEF_UNLOCK_TOL = 16;
  localparam int DEF_SETTLE_CNT = 64;
  localparam int DEF_LOCK_CNT   = 32;
  localparam int DEF_UNLOCK_CNT = 4;
  localparam int DEF_FLUSH_CYC  = 8;
  localparam int DEF_TIMEOUT    = 1024;

  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction

  function automatic logic [1:0] gear_of(input state_t s);
    return s == ST_ACQ_MED ? GEAR_MED : (s == ST_TRACK || s == ST_LOCKED) ? GEAR_NARROW : GEAR_FAST;
  endfunction
endpackage

// File: rtl/dlf_err_window.sv
// dlf_err_window: offset-binary phase error to magnitude, plus acquisition/lock/loss window flags
module dlf_err_window
  import dlf_ctrl_pkg::*;
#(
  parameter int W          = DEF_WIDTH,
  parameter int ACQ_TOL    = DEF_ACQ_TOL,
  parameter int LOCK_TOL   = DEF_LOCK_TOL,
  parameter int UNLOCK_TOL = DEF_UNLOCK_TOL
) (
  input  logic [W-1:0] phase_err,
  output logic         in_acq,
  output logic         in_lock,
  output logic         loss
);
  logic [W-1:0] s, mag;
  assign s = {~phase_err[W-1], phase_err[W-2:0]};
  // unsigned W-bit negate turns the most negative code into +2^(W-1) without wrapping
  assign mag = s[W-1] ? -s : s;
  assign in_acq  = 32'(mag) <= $unsigned(ACQ_TOL);
  assign in_lock = 32'(mag) <= $unsigned(LOCK_TOL);
  assign loss    = 32'(mag) >  $unsigned(UNLOCK_TOL);
endmodule

// File: rtl/dlf_lock_ctrl.sv
// dlf_lock_ctrl: flush, gear-shifted acquisition, lock detection and loss-of-lock supervision
module dlf_lock_ctrl
  import dlf_ctrl_pkg::*;
#(
  parameter int inout_width = DEF_WIDTH,
  parameter int ACQ_TOL     = DEF_ACQ_TOL,
  parameter int LOCK_TOL    = DEF_LOCK_TOL,
  parameter int UNLOCK_TOL  = DEF_UNLOCK_TOL,
  parameter int SETTLE_CNT  = DEF_SETTLE_CNT,
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT  = DEF_UNLOCK_CNT,
  parameter int FLUSH_CYC   = DEF_FLUSH_CYC,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic                   err_valid,
  input  logic [inout_width-1:0] phase_err,
  output logic                   filter_rstn,
  output logic [1:0]             gear,
  output logic                   locked,
  output logic                   unlock_pulse,
  output logic                   timeout_pulse
);
  localparam int MAXC = imax(imax(imax(SETTLE_CNT, LOCK_CNT), imax(UNLOCK_CNT, FLUSH_CYC)), TIMEOUT);
  localparam int CW   = $clog2(MAXC + 1);

  state_t        state, nxt;
  logic [CW-1:0] run_cnt, loss_cnt, to_cnt, fl_cnt;
  logic [CW-1:0] run_nx, loss_nx, to_nx, fl_nx;
  logic [CW-1:0] run_inc, loss_inc, to_inc, fl_inc, target;
  logic          in_acq, in_lock, loss, in_win, tp, up;

  dlf_err_window #(
    .W(inout_width), .ACQ_TOL(ACQ_TOL), .LOCK_TOL(LOCK_TOL), .UNLOCK_TOL(UNLOCK_TOL)
  ) u_win (
    .phase_err(phase_err),
    .in_acq(in_acq),
    .in_lock(in_lock),
    .loss(loss)
  );

  assign run_inc  = &run_cnt  ? run_cnt  : run_cnt  + 1'b1;
  assign loss_inc = &loss_cnt ? loss_cnt : loss_cnt + 1'b1;
  assign to_inc   = &to_cnt   ? to_cnt   : to_cnt   + 1'b1;
  assign fl_inc   = &fl_cnt   ? fl_cnt   : fl_cnt   + 1'b1;
  assign in_win   = state == ST_TRACK ? in_lock : in_acq;
  assign target   = state == ST_TRACK ? CW'(LOCK_CNT) : CW'(SETTLE_CNT);

  always_comb begin
    nxt     = state;
    run_nx  = run_cnt;
    loss_nx = loss_cnt;
    to_nx   = to_cnt;
    fl_nx   = fl_cnt;
    tp      = 1'b0;
    up      = 1'b0;
    case (state)
      ST_IDLE: nxt = enable ? ST_FLUSH : ST_IDLE;
      ST_FLUSH: begin
        fl_nx = fl_inc;
        if (fl_cnt == CW'(FLUSH_CYC - 1)) nxt = ST_ACQ_FAST;
      end
      ST_ACQ_FAST, ST_ACQ_MED, ST_TRACK: if (err_valid) begin
        run_nx = in_win ? run_inc : '0;
        to_nx  = to_inc;
        // a window hit on the timeout sample still advances the gear
        if (in_win && run_inc == target)
          nxt = state == ST_ACQ_FAST ? ST_ACQ_MED : state == ST_ACQ_MED ? ST_TRACK : ST_LOCKED;
        else if (to_inc == CW'(TIMEOUT)) begin
          nxt = ST_FLUSH;
          tp  = 1'b1;
        end
      end
      ST_LOCKED: if (err_valid) begin
        loss_nx = loss ? loss_inc : '0;
        if (loss && loss_inc == CW'(UNLOCK_CNT)) begin
          nxt = ST_ACQ_FAST;
          up  = 1'b1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
    if (!enable) begin
      nxt = ST_IDLE;
      tp  = 1'b0;
      up  = 1'b0;
    end
    if (nxt != state) begin
      run_nx  = '0;
      loss_nx = '0;
      to_nx   = '0;
      fl_nx   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      run_cnt       <= '0;
      loss_cnt      <= '0;
      to_cnt        <= '0;
      fl_cnt        <= '0;
      filter_rstn   <= 1'b0;
      gear          <= GEAR_FAST;
      locked        <= 1'b0;
      unlock_pulse  <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= nxt;
      run_cnt       <= run_nx;
      loss_cnt      <= loss_nx;
      to_cnt        <= to_nx;
      fl_cnt        <= fl_nx;
      filter_rstn   <= !(nxt inside {ST_IDLE, ST_FLUSH});
      gear          <= gear_of(nxt);
      locked        <= nxt == ST_LOCKED;
      unlock_pulse  <= up;
      timeout_pulse <= tp;
    end
  end
endmodule

// File: tb/tb_dlf_lock_ctrl.sv
// tb_dlf_lock_ctrl: directed scenarios with an event scoreboard keyed on output changes
module tb_dlf_lock_ctrl;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       enable = 1'b0;
  logic       err_valid = 1'b0;
  logic [7:0] phase_err = 8'h80;
  logic       filter_rstn, locked, unlock_pulse, timeout_pulse;
  logic [1:0] gear;
  logic [5:0] obs;
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;

  localparam logic [5:0] S_IDLE  = 6'b010000;
  localparam logic [5:0] S_FAST  = 6'b110000;
  localparam logic [5:0] S_MED   = 6'b101000;
  localparam logic [5:0] S_TRACK = 6'b100000;
  localparam logic [5:0] S_LOCK  = 6'b100100;
  localparam logic [5:0] S_UNLK  = 6'b110010;
  localparam logic [5:0] S_TO    = 6'b010001;

  typedef struct {
    int         cyc;
    logic [5:0] snap;
    string      name;
  } exp_t;
  exp_t q[$];

  dlf_lock_ctrl dut (
    .clk(clk),
    .rstn(rstn),
    .enable(enable),
    .err_valid(err_valid),
    .phase_err(phase_err),
    .filter_rstn(filter_rstn),
    .gear(gear),
    .locked(locked),
    .unlock_pulse(unlock_pulse),
    .timeout_pulse(timeout_pulse)
  );

  assign obs = {filter_rstn, gear, locked, unlock_pulse, timeout_pulse};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input logic e, input logic v, input logic [7:0] p);
    enable = e;
    err_valid = v;
    phase_err = p;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_at(input int c, input logic [5:0] s, input string n);
    q.push_back('{c, s, n});
  endtask

  task automatic check(input string n, input logic [5:0] got, input logic [5:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %b required %b", n, got, want);
    end
  endtask

  // monitor: every change of the output vector must match the next expected event
  initial begin
    logic [5:0] prev;
    exp_t e;
    prev = S_IDLE;
    forever begin
      @(negedge clk);
      if (obs !== prev) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_change: got %b at cycle %0d, required no change", obs, cyc);
        end else begin
          e = q.pop_front();
          if (obs !== e.snap || cyc != e.cyc) begin
            mismatched++;
            $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d", e.name, obs, cyc, e.snap, e.cyc);
          end
        end
        prev = obs;
      end
    end
  end

  initial begin
    int f, s, a, u, w, r, p;
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", obs, S_IDLE);
    rstn = 1'b1;
    repeat (2) step(1'b0, 1'b0, 8'h80);
    // zero error every cycle: flush, gear down, lock in cycle 169 counting FLUSH entry as 1
    f = cyc + 1;
    exp_at(f + 8, S_FAST, "acq_fast");
    exp_at(f + 72, S_MED, "acq_med");
    exp_at(f + 136, S_TRACK, "track");
    exp_at(f + 168, S_LOCK, "locked_169");
    repeat (169) step(1'b1, 1'b1, 8'h80);
    // loss bursts with idle gaps that must not count
    s = cyc;
    exp_at(s + 11, S_UNLK, "unlock_pulse");
    exp_at(s + 12, S_FAST, "unlock_drop");
    repeat (3) step(1'b1, 1'b1, 8'hA0);
    repeat (2) step(1'b1, 1'b0, 8'hA0);
    step(1'b1, 1'b1, 8'h80);
    repeat (3) step(1'b1, 1'b1, 8'hA0);
    step(1'b1, 1'b0, 8'hA0);
    step(1'b1, 1'b1, 8'hA0);
    // -128 must read as |err|=128, so acquisition never settles and times out
    exp_at(s + 1035, S_TO, "timeout_pulse");
    exp_at(s + 1036, S_IDLE, "timeout_drop");
    exp_at(s + 1043, S_FAST, "flush_8_cycles");
    for (int i = 0; i < 1024; i++) step(1'b1, 1'b1, i[0] ? 8'h00 : 8'h80);
    repeat (8) step(1'b1, 1'b1, 8'h80);
    // +13 clears the fast run, +/-12 and +/-4 sit on the window edges, +5 clears the track run
    a = cyc;
    exp_at(a + 128, S_MED, "acq_tol_plus13_clears");
    exp_at(a + 192, S_TRACK, "acq_tol_12_inside");
    exp_at(a + 256, S_LOCK, "lock_tol_4_inside");
    repeat (63) step(1'b1, 1'b1, 8'h80);
    step(1'b1, 1'b1, 8'h8D);
    repeat (64) step(1'b1, 1'b1, 8'h80);
    for (int i = 0; i < 64; i++) step(1'b1, 1'b1, i[0] ? 8'h74 : 8'h8C);
    for (int i = 0; i < 31; i++) step(1'b1, 1'b1, i[0] ? 8'h7C : 8'h84);
    step(1'b1, 1'b1, 8'h85);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, i[0] ? 8'h7C : 8'h84);
    // enable drop from LOCKED, then on the settling sample of ACQ_FAST
    u = cyc;
    exp_at(u + 1, S_IDLE, "enable_drop_locked");
    exp_at(u + 10, S_FAST, "reflush_acq_fast");
    exp_at(u + 74, S_IDLE, "enable_beats_settle");
    step(1'b0, 1'b1, 8'h80);
    repeat (9) step(1'b1, 1'b1, 8'h80);
    repeat (63) step(1'b1, 1'b1, 8'h80);
    step(1'b0, 1'b1, 8'h80);
    // reach TRACK and assert reset asynchronously mid-cycle
    w = cyc;
    exp_at(w + 9, S_FAST, "acq_fast_d");
    exp_at(w + 73, S_MED, "acq_med_d");
    exp_at(w + 137, S_TRACK, "track_d");
    repeat (142) step(1'b1, 1'b1, 8'h80);
    exp_at(cyc, S_IDLE, "async_reset_event");
    rstn = 1'b0;
    #1;
    check("async_reset_immediate", obs, S_IDLE);
    repeat (2) step(1'b1, 1'b1, 8'h80);
    rstn = 1'b1;
    r = cyc;
    exp_at(r + 9, S_FAST, "post_reset_via_idle_flush");
    repeat (9) step(1'b1, 1'b1, 8'h80);
    // settle hit on the very sample that reaches the timeout: advance, no pulse
    p = cyc;
    exp_at(p + 1024, S_MED, "settle_beats_timeout");
    for (int i = 0; i < 960; i++) step(1'b1, 1'b1, i[0] ? 8'h00 : 8'h80);
    repeat (64) step(1'b1, 1'b1, 8'h80);
    repeat (4) step(1'b1, 1'b0, 8'h80);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL pending_events: got %0d outstanding (first %s), required 0", q.size(), q[0].name);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
